// File: rtl/cpu_pkg.sv
// Shared types and constants for the fetch front end: FSM states, NOP encoding, memory sizing.
package cpu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } if_state_e;

  localparam logic [31:0] NOP_INSTR          = 32'h0000_0000;
  localparam logic [31:0] WORD_BYTES         = 32'd4;
  localparam int unsigned DEFAULT_IMEM_BYTES = 1024;

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: control inputs, instruction-memory port and IF/ID outputs.
// IF_STAGE_FETCH_COUNT_EN adds the fetch_count output.
interface if_stage_if;

  logic        start;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
  logic        halted;
  logic        misalign_err;
`ifdef IF_STAGE_FETCH_COUNT_EN
  logic [31:0] fetch_count;
`endif

  modport master (
    input  start, stall, redirect, redirect_target, imem_instr,
    output imem_addr, ifid_instr, ifid_pc4, ifid_valid, halted, misalign_err
`ifdef IF_STAGE_FETCH_COUNT_EN
    , output fetch_count
`endif
  );

  modport slave (
    output start, stall, redirect, redirect_target, imem_instr,
    input  imem_addr, ifid_instr, ifid_pc4, ifid_valid, halted, misalign_err
`ifdef IF_STAGE_FETCH_COUNT_EN
    , input fetch_count
`endif
  );

endinterface

// File: rtl/if_stage_pc_reg.sv
// Program counter: word-aligned load, +4 increment or hold; load wins over increment.
// Latency one cycle; holding is the default when neither load nor inc is asserted.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_addr,
  input  logic        inc,
  output logic [31:0] pc
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load) begin
      pc_d = load_addr & ~(WORD_BYTES - 32'd1);
    end else if (inc) begin
      pc_d = pc_q + WORD_BYTES;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC & ~(WORD_BYTES - 32'd1);
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: IDLE/RUN/HALT control, PC, IF/ID register; one-cycle fetch latency.
// Stall holds PC and IF/ID; redirect flushes and overrides stall. IF_STAGE_FETCH_COUNT_EN adds fetch_count.
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_BYTES = DEFAULT_IMEM_BYTES
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);

  if_state_e   state_q, state_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic        halted_q, halted_d;
  logic        misalign_q, misalign_d;
  logic        pc_load, pc_inc, fetch;
  logic [31:0] pc;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (pc_load),
    .load_addr (bus.redirect_target),
    .inc       (pc_inc),
    .pc        (pc)
  );

  always_comb begin
    state_d      = state_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    misalign_d   = misalign_q;
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    fetch        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bus.redirect) begin
          pc_load      = 1'b1;
          ifid_instr_d = NOP_INSTR;
          ifid_pc4_d   = '0;
          ifid_valid_d = 1'b0;
          if (bus.redirect_target[1:0] != 2'b00) misalign_d = 1'b1;
        end else if (pc >= 32'(IMEM_BYTES)) begin
          state_d      = ST_HALT;
          ifid_instr_d = NOP_INSTR;
          ifid_pc4_d   = '0;
          ifid_valid_d = 1'b0;
        end else if (!bus.stall) begin
          fetch        = 1'b1;
          pc_inc       = 1'b1;
          ifid_instr_d = bus.imem_instr;
          ifid_pc4_d   = pc + WORD_BYTES;
          ifid_valid_d = 1'b1;
        end
      end
      ST_HALT: begin
        // IF/ID already holds the bubble loaded on HALT entry
        if (bus.redirect) begin
          pc_load = 1'b1;
          state_d = ST_RUN;
          if (bus.redirect_target[1:0] != 2'b00) misalign_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    halted_d = (state_d == ST_HALT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc4_q   <= '0;
      ifid_valid_q <= 1'b0;
      halted_q     <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      halted_q     <= halted_d;
      misalign_q   <= misalign_d;
    end
  end

`ifdef IF_STAGE_FETCH_COUNT_EN
  logic [31:0] fetch_count_q, fetch_count_d;

  always_comb begin
    fetch_count_d = fetch_count_q;
    if (fetch) fetch_count_d = fetch_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
    end
  end

  assign bus.fetch_count = fetch_count_q;
`else
  logic unused_fetch;
  assign unused_fetch = fetch;
`endif

  assign bus.imem_addr    = pc;
  assign bus.ifid_instr   = ifid_instr_q;
  assign bus.ifid_pc4     = ifid_pc4_q;
  assign bus.ifid_valid   = ifid_valid_q;
  assign bus.halted       = halted_q;
  assign bus.misalign_err = misalign_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed plan steps plus random stall/redirect traffic against a behavioural fetch model.
module tb_if_stage;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  if_stage_if bus ();

  if_stage #(.RESET_PC(32'h0), .IMEM_BYTES(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [256];

  always_comb begin
    if (bus.imem_addr < 32'd1024) bus.imem_instr = mem[bus.imem_addr[9:2]];
    else                          bus.imem_instr = 32'h0;
  end

  int checks = 0;
  int errors = 0;
  int nstep  = 0;

  // Reference model: mode 0 idle, 1 running, 2 halted
  int          m_mode;
  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_mis;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a < 32'd1024) ? mem[a / 4] : 32'h0;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_pc = 0; m_instr = 0; m_pc4 = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
  endtask

  task automatic model_bubble();
    m_instr = 0; m_pc4 = 0; m_valid = 0;
  endtask

  task automatic model_edge(input logic st, input logic sl, input logic rd, input logic [31:0] tgt);
    if (m_mode == 0) begin
      if (st) m_mode = 1;
    end else if (m_mode == 1) begin
      if (rd) begin
        m_pc = (tgt / 4) * 4;
        model_bubble();
        if (tgt % 4 != 0) m_mis = 1;
      end else if (m_pc >= 1024) begin
        m_mode = 2;
        model_bubble();
      end else if (!sl) begin
        m_instr = mem_word(m_pc);
        m_pc4   = m_pc + 4;
        m_valid = 1;
        m_pc    = m_pc + 4;
        m_cnt   = m_cnt + 1;
      end
    end else begin
      if (rd) begin
        m_pc   = (tgt / 4) * 4;
        m_mode = 1;
        if (tgt % 4 != 0) m_mis = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s step%0d observed=%h expected=%h", tag, nstep, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("imem_addr", bus.imem_addr, m_pc);
    chk("ifid_instr", bus.ifid_instr, m_instr);
    chk("ifid_pc4", bus.ifid_pc4, m_pc4);
    chk("ifid_valid", {31'b0, bus.ifid_valid}, {31'b0, m_valid});
    chk("halted", {31'b0, bus.halted}, {31'b0, (m_mode == 2)});
    chk("misalign_err", {31'b0, bus.misalign_err}, {31'b0, m_mis});
`ifdef IF_STAGE_FETCH_COUNT_EN
    chk("fetch_count", bus.fetch_count, m_cnt);
`endif
  endtask

  task automatic step(input logic st, input logic sl, input logic rd, input logic [31:0] tgt);
    @(negedge clk);
    bus.start = st; bus.stall = sl; bus.redirect = rd; bus.redirect_target = tgt;
    model_edge(st, sl, rd, tgt);
    @(posedge clk);
    #1;
    nstep++;
    check_all();
  endtask

  initial begin
    bus.start = 0; bus.stall = 0; bus.redirect = 0; bus.redirect_target = 0;
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0005;
    mem[1] = 32'h2009_0003;
    model_reset();

    // Reset state
    #3;
    check_all();
    @(negedge clk);
    rst = 0;

    // Start, entry cycle, then first fetches
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("plan_word0", bus.ifid_instr, 32'h2008_0005);
    chk("plan_pc4_0", bus.ifid_pc4, 32'd4);
    step(0, 0, 0, 0);
    chk("plan_addr8", bus.imem_addr, 32'd8);

    // Stall two cycles at PC=8, then release
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    chk("stall_addr", bus.imem_addr, 32'd8);
    step(0, 0, 0, 0);
    chk("stall_rel_pc4", bus.ifid_pc4, 32'd12);

    for (int i = 0; i < 20; i++) step(0, $urandom_range(0, 3) == 0, 0, 0);

    // Redirect overrides stall; then misaligned redirect
    step(0, 1, 1, 32'h40);
    chk("redir_addr", bus.imem_addr, 32'h40);
    step(0, 0, 1, 32'h43);
    chk("misalign_set", {31'b0, bus.misalign_err}, 32'd1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0);

    for (int i = 0; i < 60; i++)
      step(0, $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0, {22'b0, 8'($urandom_range(0, 255)), 2'b00});

    // End of memory and recovery from HALT
    step(0, 0, 1, 32'd1020);
    step(0, 0, 0, 0);
    chk("last_pc4", bus.ifid_pc4, 32'd1024);
    step(0, 0, 0, 0);
    chk("halt_addr", bus.imem_addr, 32'd1024);
    step(1, 1, 0, 0);
    step(0, 0, 1, 32'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);

    // Asynchronous reset between edges at PC=0x20
    step(0, 0, 1, 32'h20);
    #2;
    rst = 1;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    rst = 0;
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);

    for (int i = 0; i < 300; i++) begin
      logic [31:0] tgt;
      tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 1100));
      step($urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 11) == 0, tgt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
